// File: rtl/spd_mul_pkg.sv
// ---------------------------------------------------------------------------
// spd_mul_pkg
// Shared definitions for the spd_mul front-end and the reduction stage:
//   - operation encodings carried on op_sel (must match the reduction stage)
//   - front-end FSM state constants
//   - LIMB_W legality check used at elaboration time
// ---------------------------------------------------------------------------
package spd_mul_pkg;

    // Operation select encodings.
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Front-end FSM states.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL      = 2'd1;
    localparam logic [1:0] ST_WAIT_FIN = 2'd2;

    // The limb width must divide 256 and give a power-of-two limb count,
    // so that the limb counter splits cleanly into (i, j) bit fields.
    function automatic bit limb_w_ok(input int w);
        return (w == 32) || (w == 64) || (w == 128);
    endfunction

endpackage

// File: rtl/spd_mul_limb.sv
// ---------------------------------------------------------------------------
// spd_mul_limb
// Combinational unsigned LIMB_W x LIMB_W -> 2*LIMB_W multiplier. Kept as its
// own module so it maps onto DSP blocks, or can be pipelined later without
// touching the accumulation logic in the top.
// Ports:
//   a_i  LIMB_W    multiplicand limb
//   b_i  LIMB_W    multiplier limb
//   p_o  2*LIMB_W  full-width product
// ---------------------------------------------------------------------------
module spd_mul_limb #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0]   a_i,
    input  logic [LIMB_W-1:0]   b_i,
    output logic [2*LIMB_W-1:0] p_o
);

    // Zero-extend both operands so the multiply is evaluated at full width.
    assign p_o = {{LIMB_W{1'b0}}, a_i} * {{LIMB_W{1'b0}}, b_i};

endmodule

// File: rtl/spd_mul_front.sv
// ---------------------------------------------------------------------------
// spd_mul_front
// Operand front-end and iterative 256x256 multiplier feeding the fast
// modular-reduction stage. One operation is accepted per start pulse in IDLE:
//   mul     : 512-bit product built limb-pair by limb-pair over NLIMB^2 cycles
//   add/sub : {a, b} forwarded as a 512-bit word
// The result is then held with a level valid until the reduction stage
// signals mod_fin_i.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      one-cycle request, sampled only in IDLE
//   op_sel_i     2-bit op (00 mul, 01 add, 10 sub, 11 illegal)
//   op_a_i/b_i   256-bit operands, needed only in the accept cycle
//   mod_fin_i    completion pulse from the reduction stage
//   busy_o       high whenever not IDLE
//   err_o        one-cycle pulse on an illegal op at start
//   op_sel_o     latched op, stable while busy
//   mod_vld_o    level valid to the reduction stage
//   p512_o       accumulator: product (mul) or {a, b} (add/sub)
// ---------------------------------------------------------------------------
module spd_mul_front
    import spd_mul_pkg::*;
#(
    parameter int LIMB_W = 64,
    parameter int NLIMB  = 256 / LIMB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [1:0]   op_sel_i,
    input  logic [255:0] op_a_i,
    input  logic [255:0] op_b_i,
    input  logic         mod_fin_i,
    output logic         busy_o,
    output logic         err_o,
    output logic [1:0]   op_sel_o,
    output logic         mod_vld_o,
    output logic [511:0] p512_o
);

    localparam int IDX_W = $clog2(NLIMB);
    localparam int CNT_W = 2 * IDX_W;

    if (!limb_w_ok(LIMB_W)) begin : g_bad_limb_w
        $error("spd_mul_front: LIMB_W must be 32, 64 or 128");
    end

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [255:0]     a_q,      a_d;
    logic [255:0]     b_q,      b_d;
    logic [1:0]       op_sel_q, op_sel_d;
    logic [511:0]     acc_q,    acc_d;
    logic             vld_q,    vld_d;
    logic             err_q,    err_d;

    // Limb indices: the counter's upper half walks a, the lower half walks b.
    logic [IDX_W-1:0]    i_idx, j_idx;
    logic [7:0]          a_base, b_base;
    logic [9:0]          shamt;
    logic [LIMB_W-1:0]   a_limb, b_limb;
    logic [2*LIMB_W-1:0] prod;
    logic [511:0]        term;

    assign i_idx  = cnt_q[CNT_W-1:IDX_W];
    assign j_idx  = cnt_q[IDX_W-1:0];
    assign a_base = 8'(i_idx) * 8'(LIMB_W);
    assign b_base = 8'(j_idx) * 8'(LIMB_W);
    assign a_limb = a_q[a_base +: LIMB_W];
    assign b_limb = b_q[b_base +: LIMB_W];
    assign shamt  = 10'(LIMB_W) * (10'(i_idx) + 10'(j_idx));

    spd_mul_limb #(
        .LIMB_W (LIMB_W)
    ) u_limb (
        .a_i (a_limb),
        .b_i (b_limb),
        .p_o (prod)
    );

    // Partial product placed at weight 2^(LIMB_W*(i+j)). The full product of
    // two 256-bit values fits in 512 bits, so truncation never loses data.
    assign term = {{(512 - 2*LIMB_W){1'b0}}, prod} << shamt;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the case statement can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_sel_d = op_sel_q;
        acc_d    = acc_q;
        vld_d    = vld_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    case (op_sel_i)
                        OP_MUL: begin
                            a_d      = op_a_i;
                            b_d      = op_b_i;
                            op_sel_d = op_sel_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = ST_MUL;
                        end
                        OP_ADD, OP_SUB: begin
                            op_sel_d = op_sel_i;
                            acc_d    = {op_a_i, op_b_i};
                            vld_d    = 1'b1;
                            state_d  = ST_WAIT_FIN;
                        end
                        OP_ILL: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = acc_q + term;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NLIMB * NLIMB - 1)) begin
                    vld_d   = 1'b1;
                    state_d = ST_WAIT_FIN;
                end
            end
            ST_WAIT_FIN: begin
                // start_i arriving here, even alongside mod_fin_i, is dropped;
                // this guarantees at least one low cycle of mod_vld_o.
                if (mod_fin_i) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the wide operand and accumulator registers are reset too, so
    // p512_o reads zero after reset rather than stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_sel_q <= OP_MUL;
            acc_q    <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_sel_q <= op_sel_d;
            acc_q    <= acc_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign err_o     = err_q;
    assign op_sel_o  = op_sel_q;
    assign mod_vld_o = vld_q;
    assign p512_o    = acc_q;

endmodule
